// File: rtl/mem_responder.sv
// Line-granular main-memory responder: one outstanding fill or writeback,
// answered after a fixed latency, with saturating completion counters.
module mem_responder #(
    parameter int unsigned DEPTH      = 4096,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned LATENCY    = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_req_valid,
    input  logic                    in_req_write,
    input  logic [31:0]             in_req_addr,
    input  logic [32*LINE_WORDS-1:0] in_req_data,
    output logic                    out_req_ready,
    output logic                    out_resp_valid,
    output logic                    out_resp_write,
    output logic [32*LINE_WORDS-1:0] out_resp_data,
    input  logic                    in_resp_ready,
    output logic [31:0]             out_read_count,
    output logic [31:0]             out_write_count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LW = 32 * LINE_WORDS;
    localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    logic [31:0] memory [DEPTH];

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   base_q, base_d;
    logic            write_q, write_d;
    logic            req_ready_q, req_ready_d;
    logic            resp_valid_q, resp_valid_d;
    logic            resp_write_q, resp_write_d;
    logic [LW-1:0]   resp_data_q, resp_data_d;
    logic [31:0]     rd_cnt_q, rd_cnt_d;
    logic [31:0]     wr_cnt_q, wr_cnt_d;

    logic            accept_c;
    logic            wr_en_c;
    logic [AW-1:0]   base_c;
    logic [LW-1:0]   rd_line_c;

    // Line-aligned word index; high address bits fall off so addresses wrap.
    assign base_c   = AW'(in_req_addr >> 2) & ~AW'(LINE_WORDS - 1);
    assign accept_c = in_req_valid & req_ready_q & reset;
    assign wr_en_c  = accept_c & in_req_write;

    always_comb begin
        rd_line_c = '0;
        for (int unsigned k = 0; k < LINE_WORDS; k++) begin
            rd_line_c[32*k +: 32] = memory[AW'(base_q + k)];
        end
    end

    // Writeback data lands in the array on the acceptance edge.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            for (int unsigned k = 0; k < LINE_WORDS; k++) begin
                memory[AW'(base_c + k)] <= in_req_data[32*k +: 32];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        base_d       = base_q;
        write_d      = write_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_write_d = resp_write_q;
        resp_data_d  = resp_data_q;
        rd_cnt_d     = rd_cnt_q;
        wr_cnt_d     = wr_cnt_q;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    state_d     = WAIT;
                    cnt_d       = CW'(LATENCY - 1);
                    base_d      = base_c;
                    write_d     = in_req_write;
                    req_ready_d = 1'b0;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_write_d = write_q;
                    resp_data_d  = write_q ? '0 : rd_line_c;
                end else begin
                    cnt_d = CW'(cnt_q - 1'b1);
                end
            end
            RESP: begin
                if (in_resp_ready) begin
                    state_d      = IDLE;
                    req_ready_d  = 1'b1;
                    resp_valid_d = 1'b0;
                    resp_write_d = 1'b0;
                    resp_data_d  = '0;
                    if (write_q) begin
                        wr_cnt_d = (wr_cnt_q == '1) ? wr_cnt_q : wr_cnt_q + 32'd1;
                    end else begin
                        rd_cnt_d = (rd_cnt_q == '1) ? rd_cnt_q : rd_cnt_q + 32'd1;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            base_q       <= '0;
            write_q      <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_write_q <= 1'b0;
            resp_data_q  <= '0;
            rd_cnt_q     <= '0;
            wr_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            base_q       <= base_d;
            write_q      <= write_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_write_q <= resp_write_d;
            resp_data_q  <= resp_data_d;
            rd_cnt_q     <= rd_cnt_d;
            wr_cnt_q     <= wr_cnt_d;
        end
    end

    assign out_req_ready   = req_ready_q;
    assign out_resp_valid  = resp_valid_q;
    assign out_resp_write  = resp_write_q;
    assign out_resp_data   = resp_data_q;
    assign out_read_count  = rd_cnt_q;
    assign out_write_count = wr_cnt_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: transaction-level model checked every cycle,
// directed literal scenarios, randomized traffic, and a LATENCY=1 instance.
module tb_mem_responder;

    localparam int unsigned DEPTH = 4096;
    localparam int unsigned LW    = 4;
    localparam int unsigned LAT   = 5;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_req_valid, in_req_write, in_resp_ready;
    logic [31:0]  in_req_addr;
    logic [127:0] in_req_data;
    logic         out_req_ready, out_resp_valid, out_resp_write;
    logic [127:0] out_resp_data;
    logic [31:0]  out_read_count, out_write_count;

    logic         v1;
    logic         r1_ready, r1_valid, r1_write;
    logic [127:0] r1_data;
    logic [31:0]  r1_rc, r1_wc;

    int total = 0;
    int bad   = 0;
    logic chk_on = 1'b0;

    always #5 clk = ~clk;

    mem_responder #(.DEPTH(DEPTH), .LINE_WORDS(LW), .LATENCY(LAT)) u0 (
        .clk(clk), .reset(reset),
        .in_req_valid(in_req_valid), .in_req_write(in_req_write),
        .in_req_addr(in_req_addr), .in_req_data(in_req_data),
        .out_req_ready(out_req_ready), .out_resp_valid(out_resp_valid),
        .out_resp_write(out_resp_write), .out_resp_data(out_resp_data),
        .in_resp_ready(in_resp_ready),
        .out_read_count(out_read_count), .out_write_count(out_write_count)
    );

    mem_responder #(.DEPTH(64), .LINE_WORDS(LW), .LATENCY(1)) u1 (
        .clk(clk), .reset(reset),
        .in_req_valid(v1), .in_req_write(1'b0),
        .in_req_addr(32'h0), .in_req_data(128'h0),
        .out_req_ready(r1_ready), .out_resp_valid(r1_valid),
        .out_resp_write(r1_write), .out_resp_data(r1_data),
        .in_resp_ready(1'b1),
        .out_read_count(r1_rc), .out_write_count(r1_wc)
    );

    // Transaction-level reference: one outstanding request, response LAT edges later.
    logic [31:0]  m_mem [DEPTH];
    logic         m_busy, m_resp, m_write;
    int unsigned  m_base, m_acc, m_cyc;
    logic [127:0] m_data;
    logic [31:0]  m_rd, m_wr;

    function automatic int unsigned base_of(input logic [31:0] a);
        return ((a >> 2) & ~(LW - 1)) % DEPTH;
    endfunction

    function automatic logic [127:0] line_of(input int unsigned b);
        logic [127:0] r;
        for (int k = 0; k < int'(LW); k++) r[32*k +: 32] = m_mem[b + k];
        return r;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy <= 1'b0; m_resp <= 1'b0; m_write <= 1'b0; m_data <= '0;
            m_rd <= 0; m_wr <= 0; m_cyc <= 0; m_acc <= 0; m_base <= 0;
        end else begin
            m_cyc <= m_cyc + 1;
            if (m_resp) begin
                if (in_resp_ready) begin
                    m_resp <= 1'b0; m_busy <= 1'b0; m_data <= '0;
                    if (m_write) m_wr <= (m_wr == 32'hFFFFFFFF) ? m_wr : m_wr + 1;
                    else         m_rd <= (m_rd == 32'hFFFFFFFF) ? m_rd : m_rd + 1;
                end
            end else if (m_busy) begin
                if (m_cyc - m_acc == LAT) begin
                    m_resp <= 1'b1;
                    m_data <= m_write ? 128'h0 : line_of(m_base);
                end
            end else if (in_req_valid) begin
                m_busy  <= 1'b1;
                m_acc   <= m_cyc;
                m_write <= in_req_write;
                m_base  <= base_of(in_req_addr);
                if (in_req_write)
                    for (int k = 0; k < int'(LW); k++)
                        m_mem[base_of(in_req_addr) + k] <= in_req_data[32*k +: 32];
            end
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Per-cycle comparison against the reference.
    always @(negedge clk) begin
        if (chk_on && reset) begin
            chk("m_ready", 128'(out_req_ready), 128'(!m_busy));
            chk("m_valid", 128'(out_resp_valid), 128'(m_resp));
            if (m_resp) chk("m_write", 128'(out_resp_write), 128'(m_write));
            chk("m_data", out_resp_data, m_data);
            chk("m_rcount", 128'(out_read_count), 128'(m_rd));
            chk("m_wcount", 128'(out_write_count), 128'(m_wr));
        end
    end

    task automatic send(input logic w, input logic [31:0] a, input logic [127:0] d);
        int n;
        in_req_valid = 1'b1; in_req_write = w; in_req_addr = a; in_req_data = d;
        n = 0;
        while (!out_req_ready && n < 100) begin @(negedge clk); n++; end
        chk("req_ready_seen", 128'(out_req_ready), 128'(1));
        @(negedge clk);
        in_req_valid = 1'b0;
    endtask

    task automatic get_resp(output logic [127:0] d, output int lat);
        lat = 0;
        while (!out_resp_valid && lat < 100) begin @(negedge clk); lat++; end
        chk("resp_valid_seen", 128'(out_resp_valid), 128'(1));
        d = out_resp_data;
        in_resp_ready = 1'b1;
        @(negedge clk);
        in_resp_ready = 1'b0;
    endtask

    logic [127:0] d;
    int           lat, nv;

    initial begin
        reset = 1'b0; in_req_valid = 1'b0; in_req_write = 1'b0;
        in_req_addr = '0; in_req_data = '0; in_resp_ready = 1'b0; v1 = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_ready", 128'(out_req_ready), 128'(1));
        chk("rst_valid", 128'(out_resp_valid), 128'(0));
        chk("rst_write", 128'(out_resp_write), 128'(0));
        chk("rst_data", out_resp_data, 128'h0);
        chk("rst_counts", 128'({out_read_count, out_write_count}), 128'(0));
        chk_on = 1'b1;

        // Fill at LATENCY=5 after preloading words 0x80..0x83.
        send(1'b1, 32'h200, 128'h00000004_00000003_00000002_00000001);
        get_resp(d, lat);
        chk("wb_ack_data", d, 128'h0);
        send(1'b0, 32'h208, 128'h0);
        get_resp(d, lat);
        chk("fill_latency", 128'(lat), 128'(5));
        chk("fill_data", d, 128'h00000004_00000003_00000002_00000001);
        chk("fill_rcount", 128'(out_read_count), 128'(1));
        chk("fill_wcount", 128'(out_write_count), 128'(1));

        // Writeback then fill of the same line via a different byte offset.
        send(1'b1, 32'h40, 128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000);
        get_resp(d, lat);
        send(1'b0, 32'h4C, 128'h0);
        get_resp(d, lat);
        chk("wbfill_data", d, 128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000);
        chk("wbfill_counts", 128'({out_read_count, out_write_count}), {64'h0, 32'd2, 32'd2});

        // Address wrap: 0x4000 maps to word 0.
        send(1'b1, 32'h0, 128'h00000044_00000033_00000022_00000011);
        get_resp(d, lat);
        send(1'b0, 32'h4000, 128'h0);
        get_resp(d, lat);
        chk("wrap_data", d, 128'h00000044_00000033_00000022_00000011);

        for (int l = 1; l < 16; l++) begin
            send(1'b1, 32'(l * 16), {$urandom, $urandom, $urandom, $urandom});
            get_resp(d, lat);
        end

        // Back-pressure with a request held during RESP.
        send(1'b0, 32'h208, 128'h0);
        lat = 0;
        while (!out_resp_valid && lat < 100) begin @(negedge clk); lat++; end
        for (int i = 0; i < 7; i++) begin
            chk("bp_valid", 128'(out_resp_valid), 128'(1));
            chk("bp_data", out_resp_data, 128'h00000004_00000003_00000002_00000001);
            chk("bp_ready", 128'(out_req_ready), 128'(0));
            if (i == 2) begin
                in_req_valid = 1'b1; in_req_write = 1'b0; in_req_addr = 32'h0;
            end
            @(negedge clk);
        end
        in_resp_ready = 1'b1;
        @(negedge clk);
        in_resp_ready = 1'b0;
        chk("bp_ready_after_hs", 128'(out_req_ready), 128'(1));
        chk("bp_valid_after_hs", 128'(out_resp_valid), 128'(0));
        chk("bp_data_after_hs", out_resp_data, 128'h0);
        @(negedge clk);
        chk("bp_held_accepted", 128'(out_req_ready), 128'(0));
        in_req_valid = 1'b0;
        get_resp(d, lat);
        chk("bp_held_latency", 128'(lat), 128'(5));
        chk("bp_held_data", d, 128'h00000044_00000033_00000022_00000011);

        // Randomized traffic over lines 0..15 with random high address bits.
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            in_req_valid  = ($urandom % 2) == 0;
            in_req_write  = ($urandom % 2) == 0;
            in_req_addr   = ($urandom & 32'hFFFF_C000) | 32'($urandom_range(0, 255));
            in_req_data   = {$urandom, $urandom, $urandom, $urandom};
            in_resp_ready = ($urandom % 3) != 0;
        end
        @(negedge clk);
        in_req_valid = 1'b0; in_resp_ready = 1'b1;
        repeat (12) @(negedge clk);
        in_resp_ready = 1'b0;

        // Asynchronous reset while a fill is waiting.
        send(1'b0, 32'h208, 128'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("arst_ready", 128'(out_req_ready), 128'(1));
        chk("arst_valid", 128'(out_resp_valid), 128'(0));
        chk("arst_counts", 128'({out_read_count, out_write_count}), 128'(0));
        nv = 0;
        for (int i = 0; i < 10; i++) begin @(negedge clk); nv += int'(out_resp_valid); end
        chk("arst_no_resp", 128'(nv), 128'(0));
        send(1'b0, 32'h208, 128'h0);
        get_resp(d, lat);
        chk("arst_mem_kept", d, 128'h00000004_00000003_00000002_00000001);

        // LATENCY=1 instance: request held and response always accepted.
        @(negedge clk);
        chk("l1_idle_ready", 128'(r1_ready), 128'(1));
        chk("l1_idle_count", 128'(r1_rc), 128'(0));
        v1 = 1'b1;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            chk("l1_ready", 128'(r1_ready), 128'(j % 3 == 2));
            chk("l1_valid", 128'(r1_valid), 128'(j % 3 == 1));
            chk("l1_count", 128'(r1_rc), 128'((j + 1) / 3));
        end
        v1 = 1'b0;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
